// File: rtl/stop_watch_pkg.sv
// Shared types and BCD time arithmetic for the stopwatch controller.
// Time is six packed BCD digits, hours tens in the MSB nibble.
package stop_watch_pkg;

    typedef struct packed {
        logic [3:0] hr_1;
        logic [3:0] hr_0;
        logic [3:0] min_1;
        logic [3:0] min_0;
        logic [3:0] sec_1;
        logic [3:0] sec_0;
    } bcd_time_t;

    localparam logic [3:0] SEC_MAX_TENS = 4'd5;
    localparam logic [3:0] MIN_MAX_TENS = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Result is {carry/borrow, digit}.
    function automatic logic [4:0] dig_inc(input logic [3:0] d, input logic [3:0] max);
        return (d == max) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    endfunction

    function automatic logic [4:0] dig_dec(input logic [3:0] d, input logic [3:0] max);
        return (d == 4'd0) ? {1'b1, max} : {1'b0, d - 4'd1};
    endfunction

    function automatic logic [6:0] bcd_hours(input bcd_time_t t);
        return (7'(t.hr_1) * 7'd10) + 7'(t.hr_0);
    endfunction

    function automatic logic bcd_at_max(input bcd_time_t t, input int unsigned hr_limit);
        return (t.sec_0 == DIGIT_MAX) && (t.sec_1 == SEC_MAX_TENS) &&
               (t.min_0 == DIGIT_MAX) && (t.min_1 == MIN_MAX_TENS) &&
               (32'(bcd_hours(t)) == (hr_limit - 32'd1));
    endfunction

    function automatic bcd_time_t bcd_inc(input bcd_time_t t, input int unsigned hr_limit);
        bcd_time_t n;
        logic      c;
        n = t;
        if (bcd_at_max(t, hr_limit)) begin
            n = '0;
        end else begin
            {c, n.sec_0} = dig_inc(t.sec_0, DIGIT_MAX);
            if (c) {c, n.sec_1} = dig_inc(t.sec_1, SEC_MAX_TENS);
            if (c) {c, n.min_0} = dig_inc(t.min_0, DIGIT_MAX);
            if (c) {c, n.min_1} = dig_inc(t.min_1, MIN_MAX_TENS);
            if (c) {c, n.hr_0}  = dig_inc(t.hr_0, DIGIT_MAX);
            if (c) n.hr_1 = t.hr_1 + 4'd1;
        end
        return n;
    endfunction

    // Saturates at zero: a countdown never wraps to the maximum.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t n;
        logic      b;
        n = t;
        if (t != '0) begin
            {b, n.sec_0} = dig_dec(t.sec_0, DIGIT_MAX);
            if (b) {b, n.sec_1} = dig_dec(t.sec_1, SEC_MAX_TENS);
            if (b) {b, n.min_0} = dig_dec(t.min_0, DIGIT_MAX);
            if (b) {b, n.min_1} = dig_dec(t.min_1, MIN_MAX_TENS);
            if (b) {b, n.hr_0}  = dig_dec(t.hr_0, DIGIT_MAX);
            if (b) n.hr_1 = t.hr_1 - 4'd1;
        end
        return n;
    endfunction

    function automatic logic bcd_valid(input bcd_time_t t, input int unsigned hr_limit);
        logic digits_ok;
        digits_ok = (t.sec_0 <= DIGIT_MAX) && (t.sec_1 <= SEC_MAX_TENS) &&
                    (t.min_0 <= DIGIT_MAX) && (t.min_1 <= MIN_MAX_TENS) &&
                    (t.hr_0 <= DIGIT_MAX)  && (t.hr_1 <= DIGIT_MAX);
        return digits_ok && (32'(bcd_hours(t)) < hr_limit);
    endfunction

endpackage

// File: rtl/stop_watch_ctrl_tick_gen.sv
// Count-unit prescaler: counts 0..TICK_DIV-1 while enabled, tick on the last value.
// tick is combinational so the time registers update on the same edge the prescaler wraps.
module tick_gen #(
    parameter int unsigned TICK_DIV = 200_000_000
) (
    input  logic clk,
    input  logic arst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned   CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TC);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stop_watch_ctrl.sv
// BCD stopwatch/timer: live time, lap hold, wrap/expiry flags and preset load.
// Per-cycle priority is clr > accepted load > tick; lap acts alongside load.
module stop_watch_ctrl
    import stop_watch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 200_000_000,
    parameter int unsigned HR_LIMIT = 24
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cnt_en,
    input  logic        clr,
    input  logic        dir,
    input  logic        load,
    input  logic [23:0] preset,
    input  logic        lap,
    output logic [23:0] time_out,
    output logic        tick,
    output logic        wrap,
    output logic        expired,
    output logic        lap_active,
    output logic        load_err
);
    bcd_time_t live_q;
    bcd_time_t lap_q;
    bcd_time_t preset_t;
    bcd_time_t live_inc;
    bcd_time_t live_dec;
    logic      preset_ok;
    logic      load_ok;
    logic      at_max;

    always_comb begin
        preset_t  = bcd_time_t'(preset);
        preset_ok = bcd_valid(preset_t, HR_LIMIT);
        load_ok   = load && preset_ok && !clr;
        live_inc  = bcd_inc(live_q, HR_LIMIT);
        live_dec  = bcd_dec(live_q);
        at_max    = bcd_at_max(live_q, HR_LIMIT);
    end

    // An accepted load restarts the count unit, just like clr.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .arst (arst),
        .en   (cnt_en),
        .clr  (clr || load_ok),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            live_q     <= '0;
            lap_q      <= '0;
            wrap       <= 1'b0;
            expired    <= 1'b0;
            lap_active <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= load && !preset_ok && !clr;
            if (clr) begin
                live_q     <= '0;
                lap_q      <= '0;
                lap_active <= 1'b0;
                expired    <= 1'b0;
            end else begin
                // Lap captures the pre-update live value, even when a load lands on the same edge.
                if (lap) begin
                    if (!lap_active) begin
                        lap_q      <= live_q;
                        lap_active <= 1'b1;
                    end else begin
                        lap_active <= 1'b0;
                    end
                end
                if (load_ok) begin
                    live_q  <= preset_t;
                    expired <= 1'b0;
                end else if (tick) begin
                    if (!dir) begin
                        live_q <= live_inc;
                        wrap   <= at_max;
                    end else begin
                        live_q <= live_dec;
                        if (live_dec == '0) begin
                            expired <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign time_out = lap_active ? lap_q : live_q;

endmodule
